// File: rtl/stepper_pkg.sv
// stepper_pkg: shared types and constants for the multi-channel stepper.
//   PHASE_TBL    - 8-entry half-step coil pattern table, index 0 at [0]
//   phase_idx_t  - 3-bit phase index (wraps mod 8)
//   step_delta_e - magnitude of one index move
//   step_idx()   - apply a signed delta to a phase index
package stepper_pkg;

  typedef logic [2:0] phase_idx_t;

  typedef enum logic [1:0] {
    DLT_NONE = 2'd0,
    DLT_ONE  = 2'd1,
    DLT_TWO  = 2'd2
  } step_delta_e;

  // Index 7 is the leftmost element, index 0 the rightmost.
  localparam logic [7:0][3:0] PHASE_TBL = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic phase_idx_t step_idx(phase_idx_t idx, logic dir, step_delta_e dlt);
    phase_idx_t mag;
    mag = (dlt == DLT_TWO) ? 3'd2 : (dlt == DLT_ONE) ? 3'd1 : 3'd0;
    return dir ? phase_idx_t'(idx + mag) : phase_idx_t'(idx - mag);
  endfunction

endpackage

// File: rtl/stepper_multi_if.sv
// stepper_multi_if: shared command port of the stepper controller.
//   cmd_valid/cmd_ready - handshake, accept on valid & ready
//   cmd_ch              - target channel
//   cmd_dir/cmd_half    - direction (1 = forward), half-step mode
//   cmd_steps/cmd_period- step count and clk cycles per step
interface stepper_multi_if #(
  parameter int CHW   = 1,
  parameter int STEPW = 16,
  parameter int PERW  = 20
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CHW-1:0]   cmd_ch;
  logic             cmd_dir;
  logic             cmd_half;
  logic [STEPW-1:0] cmd_steps;
  logic [PERW-1:0]  cmd_period;

  modport master (output cmd_valid, cmd_ch, cmd_dir, cmd_half, cmd_steps, cmd_period,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_ch, cmd_dir, cmd_half, cmd_steps, cmd_period,
                  output cmd_ready);
endinterface

// File: rtl/stepper_channel.sv
// stepper_channel: one motor channel.
//   load_i + dir/half/steps/period - start a move (only pulsed while idle)
//   abort_i  - level stop request, limit_i - async forward end-stop
//   coils_o  - phase pattern, busy_o - moving, done_o - 1-cycle end pulse
//   fault_o  - last move was cut short, pos_o - signed step position
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int STEPW = 16,
  parameter int PERW  = 20,
  parameter int POSW  = 24,
  parameter int HOLD  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dir_i,
  input  logic             half_i,
  input  logic [STEPW-1:0] steps_i,
  input  logic [PERW-1:0]  period_i,
  input  logic             abort_i,
  input  logic             limit_i,
  output logic [3:0]       coils_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [POSW-1:0]  pos_o
);

  logic             busy_q, busy_d, done_q, done_d, fault_q, fault_d;
  logic             dir_q, dir_d, half_q, half_d, first_q, first_d, en_q, en_d;
  logic [STEPW-1:0] rem_q, rem_d;
  logic [PERW-1:0]  per_q, per_d, div_q, div_d;
  phase_idx_t       idx_q, idx_d;
  logic [POSW-1:0]  pos_q, pos_d;
  logic             lim_s1_q, lim_s2_q;
  step_delta_e      dlt;

  // Full mode lands on an odd (two-coil) index with a single-index first step.
  assign dlt = (half_q || (first_q && !idx_q[0])) ? DLT_ONE : DLT_TWO;

  always_comb begin
    busy_d  = busy_q;  done_d = 1'b0;   fault_d = fault_q;
    dir_d   = dir_q;   half_d = half_q; first_d = first_q;
    rem_d   = rem_q;   per_d  = per_q;  div_d   = div_q;
    idx_d   = idx_q;   pos_d  = pos_q;
    en_d    = en_q | busy_q;
    if (load_i) begin
      dir_d   = dir_i;
      half_d  = half_i;
      rem_d   = steps_i;
      per_d   = (period_i == '0) ? PERW'(1) : period_i;
      div_d   = '0;
      fault_d = 1'b0;
      first_d = 1'b1;
      busy_d  = (steps_i != '0);
      done_d  = (steps_i == '0);
    end else if (busy_q) begin
      // Stop requests win over a step due in the same cycle.
      if (abort_i || (lim_s2_q && dir_q)) begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        fault_d = 1'b1;
      end else if (div_q == per_q - PERW'(1)) begin
        div_d   = '0;
        idx_d   = step_idx(idx_q, dir_q, dlt);
        pos_d   = dir_q ? pos_q + POSW'(1) : pos_q - POSW'(1);
        rem_d   = rem_q - STEPW'(1);
        first_d = 1'b0;
        if (rem_q == STEPW'(1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else begin
        div_d = div_q + PERW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;  done_q <= 1'b0;  fault_q <= 1'b0;
      dir_q   <= 1'b0;  half_q <= 1'b0;  first_q <= 1'b0;  en_q <= 1'b0;
      rem_q   <= '0;    per_q  <= '0;    div_q   <= '0;
      idx_q   <= '0;    pos_q  <= '0;
      lim_s1_q <= 1'b0; lim_s2_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;  done_q <= done_d;  fault_q <= fault_d;
      dir_q   <= dir_d;   half_q <= half_d;  first_q <= first_d;  en_q <= en_d;
      rem_q   <= rem_d;   per_q  <= per_d;   div_q   <= div_d;
      idx_q   <= idx_d;   pos_q  <= pos_d;
      lim_s1_q <= limit_i;
      lim_s2_q <= lim_s1_q;
    end
  end

  // Coils stay dark after reset until the channel has first been energised.
  assign coils_o = (busy_q || (HOLD != 0 && en_q)) ? PHASE_TBL[idx_q] : 4'b0000;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign fault_o = fault_q;
  assign pos_o   = pos_q;

endmodule

// File: rtl/stepper_multi.sv
// stepper_multi: NCH-channel 4-phase unipolar stepper controller.
//   clk, reset - clock, async active-high reset
//   cmd        - shared command port (slave side)
//   abort/limit- per-channel stop request / forward end-stop
//   coils      - channel i at [4i+3:4i], pos - channel i at [POSW*i +: POSW]
//   busy/done/fault - per-channel status
module stepper_multi
  import stepper_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CHW   = 1,
  parameter int STEPW = 16,
  parameter int PERW  = 20,
  parameter int POSW  = 24,
  parameter int HOLD  = 1
) (
  input  logic                clk,
  input  logic                reset,
  stepper_multi_if.slave      cmd,
  input  logic [NCH-1:0]      abort,
  input  logic [NCH-1:0]      limit,
  output logic [4*NCH-1:0]    coils,
  output logic [NCH-1:0]      busy,
  output logic [NCH-1:0]      done,
  output logic [NCH-1:0]      fault,
  output logic [POSW*NCH-1:0] pos
);

  logic [NCH-1:0] load;

  // Out-of-range channel indices are never ready.
  always_comb begin
    cmd.cmd_ready = 1'b0;
    for (int i = 0; i < NCH; i++)
      if (cmd.cmd_ch == CHW'(i)) cmd.cmd_ready = ~busy[i];
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign load[g] = cmd.cmd_valid & cmd.cmd_ready & (cmd.cmd_ch == CHW'(g));

    stepper_channel #(
      .STEPW(STEPW), .PERW(PERW), .POSW(POSW), .HOLD(HOLD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load_i   (load[g]),
      .dir_i    (cmd.cmd_dir),
      .half_i   (cmd.cmd_half),
      .steps_i  (cmd.cmd_steps),
      .period_i (cmd.cmd_period),
      .abort_i  (abort[g]),
      .limit_i  (limit[g]),
      .coils_o  (coils[4*g +: 4]),
      .busy_o   (busy[g]),
      .done_o   (done[g]),
      .fault_o  (fault[g]),
      .pos_o    (pos[POSW*g +: POSW])
    );
  end

endmodule

// File: tb/tb_stepper_multi.sv
// tb_stepper_multi: scoreboard bench for stepper_multi (HOLD=1, 2 channels)
// plus a 1-channel HOLD=0 instance for idle-coil behaviour.
module tb_stepper_multi;
  localparam int NCH = 2, CHW = 1, STEPW = 16, PERW = 20, POSW = 24;
  localparam logic [7:0][3:0] TBL = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                     4'b0110, 4'b0010, 4'b0011, 4'b0001};

  typedef struct packed { logic [3:0] pat; logic [POSW-1:0] pos; } exp_t;

  logic clk = 1'b0, reset;
  logic [NCH-1:0] abort, limit, busy, done, fault;
  logic [4*NCH-1:0] coils;
  logic [POSW*NCH-1:0] pos;
  logic abort1, limit1, busy1, done1, fault1;
  logic [3:0] coils1;
  logic [POSW-1:0] pos1;

  int n_tests = 0, n_fail = 0;
  exp_t exp_q[$];
  int idx_m[NCH];
  logic [POSW-1:0] pos_m[NCH];

  stepper_multi_if #(.CHW(CHW), .STEPW(STEPW), .PERW(PERW)) cif ();
  stepper_multi_if #(.CHW(1), .STEPW(STEPW), .PERW(PERW)) cif1 ();

  stepper_multi #(.NCH(NCH), .CHW(CHW), .STEPW(STEPW), .PERW(PERW), .POSW(POSW), .HOLD(1)) dut (
    .clk(clk), .reset(reset), .cmd(cif), .abort(abort), .limit(limit),
    .coils(coils), .busy(busy), .done(done), .fault(fault), .pos(pos));

  stepper_multi #(.NCH(1), .CHW(1), .STEPW(STEPW), .PERW(PERW), .POSW(POSW), .HOLD(0)) dut1 (
    .clk(clk), .reset(reset), .cmd(cif1), .abort(abort1), .limit(limit1),
    .coils(coils1), .busy(busy1), .done(done1), .fault(fault1), .pos(pos1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference model of the index/position walk; optionally queues expected steps.
  task automatic model_move(int ch, bit dir, bit half, int steps, bit push);
    int d;
    exp_t e;
    for (int k = 0; k < steps; k++) begin
      d = (half || (k == 0 && idx_m[ch] % 2 == 0)) ? 1 : 2;
      idx_m[ch] = dir ? (idx_m[ch] + d) % 8 : (idx_m[ch] + 8 - d) % 8;
      pos_m[ch] = dir ? pos_m[ch] + 1'b1 : pos_m[ch] - 1'b1;
      e.pat = TBL[idx_m[ch]];
      e.pos = pos_m[ch];
      if (push) exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; abort = '0; limit = '0; abort1 = 1'b0; limit1 = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_ch = '0; cif.cmd_dir = 1'b0; cif.cmd_half = 1'b0;
    cif.cmd_steps = '0; cif.cmd_period = '0;
    cif1.cmd_valid = 1'b0; cif1.cmd_ch = '0; cif1.cmd_dir = 1'b0; cif1.cmd_half = 1'b0;
    cif1.cmd_steps = '0; cif1.cmd_period = '0;
    for (int i = 0; i < NCH; i++) begin idx_m[i] = 0; pos_m[i] = '0; end
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Drive one command; returns #1 after the accepting clock edge.
  task automatic issue(int ch, bit dir, bit half, int steps, int period);
    int w;
    w = 0;
    @(negedge clk);
    cif.cmd_ch = CHW'(ch); cif.cmd_dir = dir; cif.cmd_half = half;
    cif.cmd_steps = STEPW'(steps); cif.cmd_period = PERW'(period); cif.cmd_valid = 1'b1;
    #1;
    while (!cif.cmd_ready && w < 200) begin @(negedge clk); #1; w++; end
    n_tests++;
    if (cif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready ch%0d got %b want 1", ch, cif.cmd_ready);
    end
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
  endtask

  // Pop/compare every coil change of channel ch until its done pulse.
  task automatic watch(int ch, int per, int c0, int steps, logic [3:0] p0);
    logic [3:0] prev;
    int c, last, ndone;
    exp_t e;
    prev = p0; c = c0; last = 1; ndone = 0;
    while (ndone == 0 && c < per * (steps + 2) + 20) begin
      @(negedge clk); c++;
      if (coils[4*ch +: 4] !== prev) begin
        prev = coils[4*ch +: 4];
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL step_extra ch%0d got coils=%b want no step", ch, prev);
        end else begin
          e = exp_q.pop_front();
          if (prev !== e.pat || pos[POSW*ch +: POSW] !== e.pos) begin
            n_fail++; $display("FAIL step ch%0d got coils=%b pos=%h want coils=%b pos=%h",
                               ch, prev, pos[POSW*ch +: POSW], e.pat, e.pos);
          end
        end
        n_tests++;
        if (c - last != per) begin
          n_fail++; $display("FAIL step_spacing ch%0d got %0d want %0d", ch, c - last, per);
        end
        last = c;
      end
      if (done[ch]) begin
        ndone++;
        n_tests++;
        if (busy[ch] !== 1'b0) begin
          n_fail++; $display("FAIL done_busy ch%0d got busy=%b want 0", ch, busy[ch]);
        end
      end
    end
    n_tests++;
    if (ndone != 1) begin n_fail++; $display("FAIL done_timeout ch%0d got %0d done want 1", ch, ndone); end
    @(negedge clk);
    n_tests++;
    if (done[ch] !== 1'b0 || exp_q.size() != 0 || fault[ch] !== 1'b0) begin
      n_fail++; $display("FAIL move_end ch%0d got done=%b left=%0d fault=%b want 0 0 0",
                         ch, done[ch], exp_q.size(), fault[ch]);
    end
    exp_q.delete();
  endtask

  task automatic run_move(int ch, bit dir, bit half, int steps, int period);
    logic [3:0] p0;
    p0 = TBL[idx_m[ch]];
    model_move(ch, dir, half, steps, 1'b1);
    issue(ch, dir, half, steps, period);
    watch(ch, (period == 0) ? 1 : period, 0, steps, p0);
    n_tests++;
    if (pos[POSW*ch +: POSW] !== pos_m[ch]) begin
      n_fail++; $display("FAIL final_pos ch%0d got %h want %h", ch, pos[POSW*ch +: POSW], pos_m[ch]);
    end
  endtask

  // Long move cut short by limit or abort after nb observed steps.
  task automatic stop_move(int ch, bit dir, int per, int nb, bit use_lim);
    int c, nchg, ndone;
    logic [3:0] prev;
    exp_t e;
    prev = TBL[idx_m[ch]]; c = 0; nchg = 0; ndone = 0;
    issue(ch, dir, 1'b1, 100, per);
    while (ndone == 0 && c < per * (nb + 4) + 20) begin
      @(negedge clk); c++;
      if (coils[4*ch +: 4] !== prev) begin
        prev = coils[4*ch +: 4]; nchg++;
        model_move(ch, dir, 1'b1, 1, 1'b1);
        e = exp_q.pop_front();
        n_tests++;
        if (prev !== e.pat || pos[POSW*ch +: POSW] !== e.pos) begin
          n_fail++; $display("FAIL stop_step ch%0d got coils=%b pos=%h want coils=%b pos=%h",
                             ch, prev, pos[POSW*ch +: POSW], e.pat, e.pos);
        end
        if (nchg == nb) begin
          if (use_lim) limit[ch] = 1'b1; else abort[ch] = 1'b1;
        end
      end
      if (done[ch]) ndone++;
    end
    n_tests++;
    if (ndone != 1 || nchg < nb || nchg > nb + (use_lim ? 1 : 0)) begin
      n_fail++; $display("FAIL stop_count ch%0d got steps=%0d done=%0d want steps %0d..%0d done 1",
                         ch, nchg, ndone, nb, nb + (use_lim ? 1 : 0));
    end
    n_tests++;
    if (fault[ch] !== 1'b1 || busy[ch] !== 1'b0) begin
      n_fail++; $display("FAIL stop_fault ch%0d got fault=%b busy=%b want 1 0", ch, fault[ch], busy[ch]);
    end
    abort[ch] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (coils !== '0 || busy !== '0 || done !== '0 || fault !== '0 || pos !== '0 || cif.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset got coils=%h busy=%b done=%b fault=%b pos=%h rdy=%b want 0 0 0 0 0 1",
                         coils, busy, done, fault, pos, cif.cmd_ready);
    end
  endtask

  task automatic test_half();
    run_move(0, 1'b1, 1'b1, 4, 3);
  endtask

  task automatic test_full();
    do_reset();
    run_move(0, 1'b1, 1'b0, 3, 2);
    run_move(0, 1'b0, 1'b0, 3, 2);
  endtask

  task automatic test_busy_reject();
    model_move(1, 1'b0, 1'b1, 2, 1'b1);
    issue(1, 1'b0, 1'b1, 2, 8);
    @(negedge clk);
    cif.cmd_ch = 1'b1; cif.cmd_dir = 1'b1; cif.cmd_steps = 16'd7; cif.cmd_valid = 1'b1;
    #1;
    n_tests++;
    if (cif.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", cif.cmd_ready); end
    @(negedge clk);
    n_tests++;
    if (busy[1] !== 1'b1 || pos[POSW +: POSW] !== '0) begin
      n_fail++; $display("FAIL busy_reject got busy=%b pos=%h want 1 0", busy[1], pos[POSW +: POSW]);
    end
    cif.cmd_ch = 1'b0; cif.cmd_dir = 1'b1; cif.cmd_half = 1'b1; cif.cmd_steps = 16'd1; cif.cmd_period = 20'd2;
    model_move(0, 1'b1, 1'b1, 1, 1'b0);
    #1;
    n_tests++;
    if (cif.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL other_ready got %b want 1", cif.cmd_ready); end
    @(posedge clk);
    #1 cif.cmd_valid = 1'b0;
    watch(1, 8, 2, 2, 4'b0001);
    n_tests++;
    if (pos[POSW +: POSW] !== 24'hFFFFFE || coils[7:4] !== 4'b1000) begin
      n_fail++; $display("FAIL rev_ch1 got pos=%h coils=%b want fffffe 1000", pos[POSW +: POSW], coils[7:4]);
    end
    n_tests++;
    if (busy[0] !== 1'b0 || coils[3:0] !== TBL[idx_m[0]] || pos[POSW-1:0] !== pos_m[0]) begin
      n_fail++; $display("FAIL concurrent_ch0 got coils=%b pos=%h want %b %h",
                         coils[3:0], pos[POSW-1:0], TBL[idx_m[0]], pos_m[0]);
    end
  endtask

  task automatic test_limit();
    logic [3:0] p;
    stop_move(0, 1'b1, 4, 5, 1'b1);
    // Forward move with the limit still high: accepted, then stopped without a step.
    p = coils[3:0];
    issue(0, 1'b1, 1'b1, 5, 1);
    @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b1 || fault[0] !== 1'b0) begin
      n_fail++; $display("FAIL lim_accept got busy=%b fault=%b want 1 0", busy[0], fault[0]);
    end
    @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b1 || fault[0] !== 1'b1 || coils[3:0] !== p || pos[POSW-1:0] !== pos_m[0]) begin
      n_fail++; $display("FAIL lim_first got busy=%b done=%b fault=%b coils=%b want 0 1 1 %b",
                         busy[0], done[0], fault[0], coils[3:0], p);
    end
    run_move(0, 1'b0, 1'b1, 2, 2);
    limit[0] = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    logic [3:0] p;
    p = coils[3:0];
    abort[0] = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (busy[0] !== 1'b0 || done[0] !== 1'b0 || fault[0] !== 1'b0 || coils[3:0] !== p) begin
      n_fail++; $display("FAIL abort_idle got busy=%b done=%b fault=%b coils=%b want 0 0 0 %b",
                         busy[0], done[0], fault[0], coils[3:0], p);
    end
    abort[0] = 1'b0;
    stop_move(1, 1'b0, 3, 2, 1'b0);
  endtask

  task automatic test_zero_steps();
    int w;
    issue(0, 1'b1, 1'b1, 0, 5);
    @(negedge clk);
    n_tests++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_done got done=%b busy=%b want 1 0", done[0], busy[0]);
    end
    @(negedge clk);
    n_tests++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0 || pos[POSW-1:0] !== pos_m[0]) begin
      n_fail++; $display("FAIL zero_after got done=%b busy=%b pos=%h want 0 0 %h", done[0], busy[0], pos[POSW-1:0], pos_m[0]);
    end
    run_move(0, 1'b1, 1'b1, 2, 0);
    // HOLD=0 instance: dark when idle, energised while moving.
    n_tests++;
    if (coils1 !== 4'b0000) begin n_fail++; $display("FAIL hold0_idle got %b want 0000", coils1); end
    @(negedge clk);
    cif1.cmd_ch = 1'b0; cif1.cmd_dir = 1'b1; cif1.cmd_half = 1'b1;
    cif1.cmd_steps = 16'd2; cif1.cmd_period = 20'd2; cif1.cmd_valid = 1'b1;
    @(posedge clk);
    #1 cif1.cmd_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if (coils1 !== 4'b0001 || busy1 !== 1'b1) begin
      n_fail++; $display("FAIL hold0_busy got coils=%b busy=%b want 0001 1", coils1, busy1);
    end
    w = 0;
    while (!done1 && w < 50) begin @(negedge clk); w++; end
    n_tests++;
    if (done1 !== 1'b1 || coils1 !== 4'b0000 || pos1 !== 24'd2 || busy1 !== 1'b0) begin
      n_fail++; $display("FAIL hold0_end got done=%b coils=%b pos=%h busy=%b want 1 0000 2 0", done1, coils1, pos1, busy1);
    end
  endtask

  task automatic test_reset_mid();
    int c, nchg;
    logic [3:0] prev;
    prev = TBL[idx_m[0]]; c = 0; nchg = 0;
    issue(0, 1'b1, 1'b1, 10, 3);
    while (nchg < 3 && c < 40) begin
      @(negedge clk); c++;
      if (coils[3:0] !== prev) begin prev = coils[3:0]; nchg++; end
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (nchg != 3 || coils !== '0 || busy !== '0 || pos !== '0 || fault !== '0) begin
      n_fail++; $display("FAIL reset_mid got steps=%0d coils=%h busy=%b pos=%h fault=%b want 3 0 0 0 0",
                         nchg, coils, busy, pos, fault);
    end
    do_reset();
    run_move(0, 1'b1, 1'b1, 1, 1);
  endtask

  initial begin
    test_reset();
    test_half();
    test_full();
    test_busy_reject();
    test_limit();
    test_abort();
    test_zero_steps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
